// File: rtl/shift_pkg.sv
// Shared encodings and default sizing for the shift sequencer block.
package shift_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNTW  = 4;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_ROL = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle for shift_sequencer; master drives requests, slave is the sequencer.
interface shift_sequencer_if
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNTW  = DEF_CNTW
);

  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] In;
  logic [CNTW-1:0]  Cnt;
  logic [1:0]       Op;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] Out;
  logic             Busy;

  modport master (
    output InValid, In, Cnt, Op, OutReady,
    input  InReady, OutValid, Out, Busy
  );

  modport slave (
    input  InValid, In, Cnt, Op, OutReady,
    output InReady, OutValid, Out, Busy
  );

endinterface

// File: rtl/shift_step1.sv
// Combinational single-bit shift/rotate step.
// Rotate wrap exists only when SHIFT_SEQ_ROTATE_EN is defined; otherwise ROL/ROR act as SLL/SRL.
module shift_step1
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] In,
  input  logic [1:0]       Op,
  output logic [WIDTH-1:0] Out
);

  // One-bit step selected by the latched operation
  always_comb begin
    Out = In;
    case (Op)
      OP_SLL:  Out = {In[WIDTH-2:0], 1'b0};
      OP_SRL:  Out = {1'b0, In[WIDTH-1:1]};
`ifdef SHIFT_SEQ_ROTATE_EN
      OP_ROL:  Out = {In[WIDTH-2:0], In[WIDTH-1]};
      OP_ROR:  Out = {In[0], In[WIDTH-1:1]};
`else
      OP_ROL:  Out = {In[WIDTH-2:0], 1'b0};
      OP_ROR:  Out = {1'b0, In[WIDTH-1:1]};
`endif
      default: Out = In;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: one bit per cycle, Cnt+1 cycles from request to result.
// Optional rotate support via SHIFT_SEQ_ROTATE_EN (handled inside shift_step1).
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNTW  = DEF_CNTW
) (
  input  logic               clk,
  input  logic               rst,
  shift_sequencer_if.slave   bus
);

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1'b1);

  state_e           state_r;
  state_e           state_nx_s;
  logic [WIDTH-1:0] work_r;
  logic [WIDTH-1:0] step_s;
  logic [CNTW-1:0]  cnt_r;
  logic [1:0]       op_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;

  shift_step1 #(.WIDTH(WIDTH)) u_step (
    .In  (work_r),
    .Op  (op_r),
    .Out (step_s)
  );

  // Next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.InValid) begin
          if (bus.Cnt == '0) begin
            state_nx_s = DONE;
          end else begin
            state_nx_s = SHIFT;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == CNT_ONE) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = SHIFT;
        end
      end
      DONE: begin
        if (bus.OutReady) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State, datapath and registered status flags (flags follow the next state)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      work_r      <= '0;
      cnt_r       <= '0;
      op_r        <= OP_SLL;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      in_ready_r  <= (state_nx_s == IDLE);
      out_valid_r <= (state_nx_s == DONE);
      busy_r      <= (state_nx_s == SHIFT) || (state_nx_s == DONE);
      case (state_r)
        IDLE: begin
          if (bus.InValid) begin
            work_r <= bus.In;
            cnt_r  <= bus.Cnt;
            op_r   <= bus.Op;
          end
        end
        SHIFT: begin
          work_r <= step_s;
          cnt_r  <= cnt_r - CNT_ONE;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.InReady  = in_ready_r;
  assign bus.OutValid = out_valid_r;
  assign bus.Busy     = busy_r;
  assign bus.Out      = work_r;

endmodule
